// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator slice.
//   state_t  : accumulator FSM states (ACCUM collects products, HOLD presents a result)
//   ACC_W    : product / sum width
//   COUNT_W  : width of the per-group term counter
//   ACC_MAX  : largest representable signed sum (positive clamp value)
//   ACC_MIN  : smallest representable signed sum (negative clamp value)
package product_acc_pkg;

  localparam int ACC_W   = 64;
  localparam int COUNT_W = 8;

  localparam logic [ACC_W-1:0] ACC_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [ACC_W-1:0] ACC_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator and the result consumer.
//   in_valid/in_ready/in_prod/in_last     : product stream into the accumulator
//   out_valid/out_ready/out_sum/out_count/out_ovf : group result stream out
// Modports:
//   master : the environment side (drives products, accepts results)
//   slave  : the accumulator side
interface product_accumulator_if;
  import product_acc_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [ACC_W-1:0]   in_prod;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/sat_add64.sv
// Combinational 64-bit signed add with saturation.
//   a, b : signed two's-complement operands
//   sum  : a + b clamped to [ACC_MIN, ACC_MAX]
//   sat  : high when the clamp was applied
module sat_add64
  import product_acc_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum,
  output logic        sat
);

  logic [64:0] wide;

  // NOTE: every combinational output gets a default at the top of the block so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wide = {a[63], a} + {b[63], b};
    sum  = wide[63:0];
    sat  = 1'b0;
    // The 65-bit result fits in 64 bits only when its top two bits agree; the
    // extra sign bit tells which direction overflowed.
    if (wide[64] != wide[63]) begin
      sat = 1'b1;
      sum = wide[64] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Signed saturating accumulator for groups of 64-bit products.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : product input stream and group-result output stream (slave side)
// A group closes on a product flagged in_last, or when MAX_TERMS products have
// been accepted. The result is then held on the output until taken; no new
// products are accepted while the result is pending.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int MAX_TERMS = 16,
  parameter int W         = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q;
  logic [COUNT_W-1:0] count_q;
  logic               ovf_q;

  logic [COUNT_W-1:0] count_inc;
  logic [W-1:0]       sum_next;
  logic               sat_hit;
  logic               accept;
  logic               take;
  logic               closes;

  sat_add64 u_sat_add (
    .a   (acc_q),
    .b   (bus.in_prod),
    .sum (sum_next),
    .sat (sat_hit)
  );

  assign count_inc = count_q + 1'b1;
  assign closes    = bus.in_last || (count_inc == COUNT_W'(MAX_TERMS));

  // Handshakes depend only on the registered state, so ready/valid never
  // combinationally follow the opposite side's valid/ready.
  assign accept = bus.in_valid  && (state_q == ACCUM);
  assign take   = bus.out_ready && (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && closes) state_d = HOLD;
      HOLD:  if (take)             state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q   <= sum_next;
        count_q <= count_inc;
        ovf_q   <= ovf_q | sat_hit;
      end else if (take) begin
        acc_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios followed by a
// randomized run, all compared against a group-level reference model.
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam int MAX_T = 16;
  localparam logic signed [64:0] LIM_HI = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] LIM_LO = 65'sh1_8000_0000_0000_0000;

  logic clk;
  logic rst;

  product_accumulator_if bus ();

  product_accumulator #(.MAX_TERMS(MAX_T), .W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the group being built and whether a result is pending.
  bit          m_hold;
  logic [63:0] m_acc;
  int          m_cnt;
  bit          m_ovf;

  // Bookkeeping of observed traffic.
  int          n_acc;        // accepted input handshakes
  int          n_out_terms;  // sum of out_count over taken results
  bit          last_acc;
  logic [63:0] last_sum;
  logic [63:0] last_cnt;
  logic [63:0] last_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_hold = 1'b0;
    m_acc  = '0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
  endtask

  // Reference for one accepted product: exact sum, clamped to the 64-bit range.
  task automatic model_add(input logic [63:0] p, input bit last);
    logic signed [64:0] s;
    s = $signed(m_acc) + $signed(p);
    if (s > LIM_HI) begin
      m_acc = ACC_MAX;
      m_ovf = 1'b1;
    end else if (s < LIM_LO) begin
      m_acc = ACC_MIN;
      m_ovf = 1'b1;
    end else begin
      m_acc = s[63:0];
    end
    m_cnt++;
    if (last || m_cnt == MAX_T) m_hold = 1'b1;
  endtask

  // One clock cycle: apply inputs, check the DUT against the model, advance.
  task automatic cycle(input bit v, input logic [63:0] p, input bit l, input bit r);
    bit acc;
    bit tk;
    bus.in_valid  = v;
    bus.in_prod   = p;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    check("in_ready",  64'(bus.in_ready),  64'(!m_hold));
    check("out_valid", 64'(bus.out_valid), 64'(m_hold));
    if (m_hold) begin
      check("out_sum",   bus.out_sum,        m_acc);
      check("out_count", 64'(bus.out_count), 64'(m_cnt));
      check("out_ovf",   64'(bus.out_ovf),   64'(m_ovf));
    end
    acc = v && !m_hold;
    tk  = m_hold && r;
    if (tk) begin
      last_sum = bus.out_sum;
      last_cnt = 64'(bus.out_count);
      last_ovf = 64'(bus.out_ovf);
      n_out_terms += int'(bus.out_count);
    end
    @(posedge clk);
    #1;
    last_acc = acc;
    if (tk) model_clear();
    else if (acc) begin
      n_acc++;
      model_add(p, l);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   bus.out_sum,        64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
  endtask

  function automatic logic [63:0] rand_prod();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       rand_prod = {{48{r[15]}}, r[15:0]};
      1:       rand_prod = ACC_MAX - 64'($urandom_range(0, 255));
      2:       rand_prod = ACC_MIN + 64'($urandom_range(0, 255));
      default: rand_prod = r;
    endcase
  endfunction

  initial begin
    bit          have;
    bit          offered;
    bit          v;
    bit          l;
    logic [63:0] p;
    int          base_acc;

    n_acc = 0;
    n_out_terms = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single group 5, -3, 10.
    cycle(1'b1, 64'd5, 1'b0, 1'b1);
    cycle(1'b1, -64'sd3, 1'b0, 1'b1);
    cycle(1'b1, 64'd10, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("single_sum",   last_sum, 64'd12);
    check("single_count", last_cnt, 64'd3);
    check("single_ovf",   last_ovf, 64'd0);

    // Auto-close at MAX_TERMS.
    for (int i = 0; i < MAX_T; i++) cycle(1'b1, 64'd1, 1'b0, 1'b1);
    check("auto_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 64'd1, 1'b0, 1'b1);
    check("auto_sum",   last_sum, 64'd16);
    check("auto_count", last_cnt, 64'd16);
    check("auto_term1_accepted", 64'(last_acc), 64'd0);
    cycle(1'b1, 64'd7, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("auto_next_sum", last_sum, 64'd7);

    // Positive saturation.
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFF0, 1'b0, 1'b1);
    cycle(1'b1, 64'h20, 1'b0, 1'b1);
    cycle(1'b1, -64'sh10, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("possat_sum", last_sum, 64'h7FFF_FFFF_FFFF_FFEF);
    check("possat_ovf", last_ovf, 64'd1);

    // Negative saturation.
    cycle(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("negsat_sum", last_sum, 64'h8000_0000_0000_0000);
    check("negsat_ovf", last_ovf, 64'd1);

    // Backpressure with a product waiting upstream.
    cycle(1'b1, 64'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'd99, 1'b0, 1'b0);
      check("bp_stable_sum", bus.out_sum, 64'd3);
    end
    cycle(1'b1, 64'd99, 1'b0, 1'b1);
    check("bp_taken_sum", last_sum, 64'd3);
    cycle(1'b1, 64'd99, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("bp_next_sum",   last_sum, 64'd99);
    check("bp_next_count", last_cnt, 64'd1);

    // Reset mid-group.
    cycle(1'b1, 64'd7, 1'b0, 1'b1);
    cycle(1'b1, 64'd8, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 64'd2, 1'b1, 1'b1);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("post_rst_sum",   last_sum, 64'd2);
    check("post_rst_count", last_cnt, 64'd1);

    // Randomized traffic with stalls on both sides.
    base_acc    = n_acc;
    n_out_terms = 0;
    have        = 1'b0;
    offered     = 1'b0;
    p           = '0;
    l           = 1'b0;
    for (int c = 0; c < 20000 && (n_acc - base_acc) < 1000; c++) begin
      if (!have) begin
        p    = rand_prod();
        l    = ($urandom_range(0, 4) == 0);
        have = 1'b1;
      end
      v = offered || ($urandom_range(0, 3) != 0);
      offered = v;
      cycle(v, p, l, ($urandom_range(0, 2) != 0));
      if (last_acc) begin
        have    = 1'b0;
        offered = 1'b0;
      end
    end
    check("random_accepts", 64'(n_acc - base_acc), 64'd1000);
    for (int k = 0; k < 4 && m_hold; k++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    if (m_cnt > 0) cycle(1'b1, 64'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4 && m_hold; k++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    check("random_term_total", 64'(n_out_terms), 64'(n_acc - base_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
